// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage PC sequencer: arbitrates redirect / imem wait / load-use stall / advance.
// Optional perf counters are built only when PC_SEQ_PERF_EN is defined.
module pc_fetch_sequencer #(
  parameter int FLUSH_DEPTH = 2,
  parameter int MAX_STALL   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hz_stall,
  input  logic        imem_ready,
  input  logic        ex_is_cb,
  input  logic        ex_is_b,
  input  logic        ex_is_br,
  input  logic        ex_cond_met,
  output logic        pc_en,
  output logic        pc_sel_branch,
  output logic        pc_sel_uncond,
  output logic        pc_sel_reg,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        fetch_valid,
  output logic        stall_timeout,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_stalls
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    SHADOW = 2'd2
  } seqState_t;

  seqState_t  state, stateNext;
  logic [1:0] shadowCnt, shadowCntNext;
  logic [7:0] stallCnt;
  logic       taken;
  logic       stallCycle;

  assign taken      = ex_is_br | ex_is_b | (ex_is_cb & ex_cond_met);
  assign stallCycle = (state == RUN) && !taken && imem_ready && hz_stall;

  // NOTE: every output and next-state value gets a default first, so no path
  // through the case below can leave one unassigned and infer a latch.
  always_comb begin
    stateNext     = state;
    shadowCntNext = shadowCnt;
    pc_en         = 1'b0;
    pc_sel_branch = 1'b0;
    pc_sel_uncond = 1'b0;
    pc_sel_reg    = 1'b0;
    ifid_en       = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    fetch_valid   = 1'b0;
    case (state)
      BOOT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        stateNext  = RUN;
      end
      RUN: begin
        if (taken) begin
          // BR outranks B, which outranks CB when several are asserted
          pc_en         = 1'b1;
          pc_sel_reg    = ex_is_br;
          pc_sel_branch = ~ex_is_br;
          pc_sel_uncond = ex_is_b & ~ex_is_br;
          ifid_en       = 1'b1;
          ifid_flush    = 1'b1;
          idex_flush    = (FLUSH_DEPTH >= 2);
          if (FLUSH_DEPTH > 1) begin
            stateNext     = SHADOW;
            shadowCntNext = 2'(FLUSH_DEPTH - 1);
          end
        end else if (!imem_ready) begin
          ifid_flush = 1'b1;
        end else if (hz_stall) begin
          idex_flush  = 1'b1;
          fetch_valid = 1'b1;
        end else begin
          pc_en       = 1'b1;
          ifid_en     = 1'b1;
          fetch_valid = 1'b1;
        end
      end
      SHADOW: begin
        // Wrong-path branches and stalls are ignored; only imem wait holds the PC.
        if (imem_ready) begin
          pc_en         = 1'b1;
          ifid_en       = 1'b1;
          fetch_valid   = 1'b1;
          shadowCntNext = shadowCnt - 2'd1;
          if (shadowCnt == 2'd1) stateNext = RUN;
        end else begin
          ifid_flush = 1'b1;
        end
      end
      default: stateNext = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= BOOT;
      shadowCnt     <= 2'd0;
      stallCnt      <= 8'd0;
      stall_timeout <= 1'b0;
    end else begin
      state     <= stateNext;
      shadowCnt <= shadowCntNext;
      if (stallCycle) begin
        if (stallCnt != 8'hFF) stallCnt <= stallCnt + 8'd1;
        if ((int'(stallCnt) + 1) >= MAX_STALL) stall_timeout <= 1'b1;
      end else begin
        stallCnt <= 8'd0;
      end
    end
  end

`ifdef PC_SEQ_PERF_EN
  logic        redirect;
  logic [31:0] perfRedir, perfStall;

  assign redirect = (state == RUN) && taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perfRedir <= 32'd0;
      perfStall <= 32'd0;
    end else begin
      if (redirect && perfRedir != 32'hFFFF_FFFF) perfRedir <= perfRedir + 32'd1;
      if (stallCycle && perfStall != 32'hFFFF_FFFF) perfStall <= perfStall + 32'd1;
    end
  end

  assign perf_redirects = perfRedir;
  assign perf_stalls    = perfStall;
`else
  assign perf_redirects = 32'd0;
  assign perf_stalls    = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: per-cycle behavioural model plus
// directed literal checks, then randomized traffic with occasional resets.
module tb_pc_fetch_sequencer;

  localparam int FD = 2;
  localparam int MS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        hz_stall, imem_ready, ex_is_cb, ex_is_b, ex_is_br, ex_cond_met;
  logic        pc_en, pc_sel_branch, pc_sel_uncond, pc_sel_reg;
  logic        ifid_en, ifid_flush, idex_flush, fetch_valid, stall_timeout;
  logic [31:0] perf_redirects, perf_stalls;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct packed {
    logic pcEn, selBranch, selUncond, selReg, ifidEn, ifidFlush, idexFlush, fetchValid, timeout;
  } outs_t;

  pc_fetch_sequencer #(.FLUSH_DEPTH(FD), .MAX_STALL(MS)) dut (
    .clk(clk), .rst(rst),
    .hz_stall(hz_stall), .imem_ready(imem_ready),
    .ex_is_cb(ex_is_cb), .ex_is_b(ex_is_b), .ex_is_br(ex_is_br), .ex_cond_met(ex_cond_met),
    .pc_en(pc_en), .pc_sel_branch(pc_sel_branch), .pc_sel_uncond(pc_sel_uncond),
    .pc_sel_reg(pc_sel_reg), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .fetch_valid(fetch_valid), .stall_timeout(stall_timeout),
    .perf_redirects(perf_redirects), .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: bookkeeping in plain integers, evaluated mid-cycle.
  bit     mBoot = 1'b1;
  int     mShadow = 0;
  int     mStallRun = 0;
  bit     mTimeout = 1'b0;
  longint mRedir = 0;
  longint mStalls = 0;

  always @(negedge clk) begin
    outs_t e, a;
    bit    isStall, isRedir, tk;
    if (!rst) begin
      mBoot = 1'b1; mShadow = 0; mStallRun = 0; mTimeout = 1'b0; mRedir = 0; mStalls = 0;
    end
    e = '0;
    e.timeout = mTimeout;
    isStall = 1'b0;
    isRedir = 1'b0;
    tk = ex_is_br | ex_is_b | (ex_is_cb & ex_cond_met);
    if (mBoot) begin
      e.ifidFlush = 1'b1; e.idexFlush = 1'b1;
      if (rst) mBoot = 1'b0;
    end else if (mShadow > 0) begin
      if (imem_ready) begin
        e.pcEn = 1'b1; e.ifidEn = 1'b1; e.fetchValid = 1'b1;
        mShadow--;
      end else e.ifidFlush = 1'b1;
    end else if (tk) begin
      isRedir     = 1'b1;
      e.pcEn      = 1'b1;
      e.selReg    = ex_is_br;
      e.selBranch = !ex_is_br;
      e.selUncond = ex_is_b && !ex_is_br;
      e.ifidEn    = 1'b1;
      e.ifidFlush = 1'b1;
      e.idexFlush = (FD >= 2);
      mShadow     = FD - 1;
    end else if (!imem_ready) begin
      e.ifidFlush = 1'b1;
    end else if (hz_stall) begin
      isStall = 1'b1;
      e.idexFlush = 1'b1; e.fetchValid = 1'b1;
    end else begin
      e.pcEn = 1'b1; e.ifidEn = 1'b1; e.fetchValid = 1'b1;
    end
    a = {pc_en, pc_sel_branch, pc_sel_uncond, pc_sel_reg, ifid_en, ifid_flush,
         idex_flush, fetch_valid, stall_timeout};
    check("cycle outputs", 32'(a), 32'(e));
`ifdef PC_SEQ_PERF_EN
    check("cycle perf_redirects", perf_redirects, 32'(mRedir));
    check("cycle perf_stalls", perf_stalls, 32'(mStalls));
`else
    check("cycle perf_redirects", perf_redirects, 32'd0);
    check("cycle perf_stalls", perf_stalls, 32'd0);
`endif
    if (rst) begin
      if (isStall) begin
        if (mStallRun + 1 >= MS) mTimeout = 1'b1;
        if (mStallRun < 255) mStallRun++;
        mStalls++;
      end else mStallRun = 0;
      if (isRedir) mRedir++;
    end
  end

  // Inputs change 2 time units after the rising edge; literal checks at +3.
  task automatic drive(input bit r, input bit hz, input bit rdy, input bit cb,
                       input bit b, input bit br, input bit cm);
    @(posedge clk);
    #2;
    rst = r; hz_stall = hz; imem_ready = rdy;
    ex_is_cb = cb; ex_is_b = b; ex_is_br = br; ex_cond_met = cm;
    #1;
  endtask

  initial begin
    rst = 1'b0; hz_stall = 1'b0; imem_ready = 1'b0;
    ex_is_cb = 1'b0; ex_is_b = 1'b0; ex_is_br = 1'b0; ex_cond_met = 1'b0;

    // Reset, release, advance
    drive(0, 0, 1, 0, 0, 0, 0);
    check("t1 reset ifid_flush", 32'(ifid_flush), 32'd1);
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0);
    check("t1 boot pc_en", 32'(pc_en), 32'd0);
    check("t1 boot fetch_valid", 32'(fetch_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 0, 0, 0, 0);
      check("t1 advance", 32'({pc_en, pc_sel_branch, pc_sel_uncond, pc_sel_reg}), 32'b1000);
    end

    // CBZ taken, wrong-path B ignored, not-taken CBZ advances
    drive(1, 0, 1, 1, 0, 0, 1);
    check("t2 cbz redirect",
          32'({pc_en, pc_sel_branch, pc_sel_uncond, ifid_flush, idex_flush}), 32'b11011);
    drive(1, 0, 1, 0, 1, 0, 0);
    check("t2 shadow ignores B", 32'({pc_en, pc_sel_branch, pc_sel_uncond}), 32'b100);
    drive(1, 0, 1, 1, 0, 0, 0);
    check("t2 cbz not taken",
          32'({pc_en, pc_sel_branch, pc_sel_uncond, pc_sel_reg, fetch_valid}), 32'b10001);

    // Redirect beats stall and imem wait
    drive(1, 1, 0, 0, 0, 1, 0);
    check("t3 br wins", 32'({pc_en, pc_sel_reg, pc_sel_branch}), 32'b110);
    drive(1, 0, 1, 0, 0, 0, 0);

    // Three-cycle load-use stall from a fresh reset
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 0, 0, 0);
      check("t4 stall", 32'({pc_en, ifid_en, idex_flush}), 32'b001);
    end
    drive(1, 0, 1, 0, 0, 0, 0);
    check("t4 resume", 32'({pc_en, ifid_en, idex_flush}), 32'b110);
`ifdef PC_SEQ_PERF_EN
    check("t4 perf_stalls", perf_stalls, 32'd3);
`else
    check("t4 perf_stalls", perf_stalls, 32'd0);
`endif

    // Watchdog
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < MS; i++) begin
      drive(1, 1, 1, 0, 0, 0, 0);
      if (i == MS - 1) check("t5 timeout before limit", 32'(stall_timeout), 32'd0);
    end
    drive(1, 0, 1, 0, 0, 0, 0);
    check("t5 timeout set", 32'(stall_timeout), 32'd1);
    repeat (3) drive(1, 0, 1, 0, 0, 0, 0);
    check("t5 timeout sticky", 32'(stall_timeout), 32'd1);
    drive(0, 0, 1, 0, 0, 0, 0);
    check("t5 timeout cleared", 32'(stall_timeout), 32'd0);

    // Reset while in the flush shadow
    drive(1, 0, 1, 0, 0, 0, 0);
    drive(1, 0, 1, 1, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 0, 0);
    check("t6 reset in shadow", 32'({ifid_flush, pc_en}), 32'b10);
    check("t6 perf_redirects", perf_redirects, 32'd0);

    // Randomized traffic
    drive(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 9) < 8),
            ($urandom_range(0, 9) < 2),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 1) == 1));
    end
    drive(1, 0, 1, 0, 0, 0, 0);
    @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Control sequencer for the fetch-stage program counter of the 5-stage pipeline. Each cycle it decides whether the PC holds, advances by 4, or redirects to a branch target. It drives the PC write-enable and the three target-select lines (branch, uncondBr, branchReg), plus IF/ID and ID/EX enable/flush. It arbitrates between branch redirects from the resolving stage, load-use stalls from the hazard unit, and instruction-memory wait states, and suppresses wrong-path branches in the flush shadow.

Parameters:
FLUSH_DEPTH, 2, number of younger pipeline slots squashed on a redirect (legal 1..3); also the shadow length in cycles.
MAX_STALL, 16, consecutive stall cycles tolerated before stall_timeout is raised (legal 1..255).

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  asynchronous, active-low reset (asserted when 0).
hz_stall  in  1  load-use stall request from the hazard unit.
imem_ready  in  1  instruction memory has valid data for the current PC.
ex_is_cb  in  1  conditional branch (CBZ/B.cond) in the resolving stage.
ex_is_b  in  1  unconditional B/BL in the resolving stage.
ex_is_br  in  1  BR (register target) in the resolving stage.
ex_cond_met  in  1  branch condition true (e.g. zero flag for CBZ).
pc_en  out  1  PC register load enable.
pc_sel_branch  out  1  select PC+offset instead of PC+4.
pc_sel_uncond  out  1  select the 26-bit offset instead of the 19-bit offset.
pc_sel_reg  out  1  select the register target.
ifid_en  out  1  IF/ID pipeline register enable.
ifid_flush  out  1  squash IF/ID contents.
idex_flush  out  1  squash ID/EX contents (bubble insert).
fetch_valid  out  1  the current fetch is architecturally valid.
stall_timeout  out  1  sticky: hz_stall exceeded MAX_STALL cycles.
perf_redirects  out  32  redirect count (feature-gated).
perf_stalls  out  32  stall cycle count (feature-gated).

Behaviour:
- States: BOOT, RUN, SHADOW. Outputs are combinational from state, inputs and counters; state and counters are registered.
- Reset (rst=0, asynchronous): state=BOOT, shadow_cnt=0, stall_cnt=0, stall_timeout=0, perf counters=0. While in reset and in BOOT: pc_en=0, all pc_sel*=0, ifid_en=0, ifid_flush=1, idex_flush=1, fetch_valid=0.
- BOOT: lasts exactly one rising edge after rst releases, then moves to RUN. The PC stays at 0.
- taken = ex_is_br | ex_is_b | (ex_is_cb & ex_cond_met). It is evaluated only in RUN.
- RUN priority is redirect > imem wait > stall > advance:
  - Redirect (taken=1):
    - pc_en=1.
    - pc_sel_reg=ex_is_br.
    - pc_sel_branch=~ex_is_br.
    - pc_sel_uncond=ex_is_b.
    - ifid_flush=1, and idex_flush=1 if FLUSH_DEPTH>=2.
    - fetch_valid=0.
    - Next state is SHADOW with shadow_cnt=FLUSH_DEPTH-1, or RUN if FLUSH_DEPTH=1.
    - Applies even when hz_stall=1 or imem_ready=0.
  - If more than one of ex_is_br/ex_is_b/ex_is_cb is asserted, ex_is_br wins, then ex_is_b.
  - imem wait (imem_ready=0): pc_en=0, ifid_en=0, ifid_flush=1, fetch_valid=0.
  - Stall (hz_stall=1): pc_en=0, ifid_en=0, idex_flush=1, fetch_valid=1.
  - Advance: pc_en=1, all selects 0, ifid_en=1, no flush, fetch_valid=1.
- SHADOW:
  - Branch inputs and hz_stall are ignored (wrong-path).
  - imem_ready=0 holds the PC (pc_en=0) without decrementing shadow_cnt; otherwise the block advances as in RUN.
  - shadow_cnt decrements on each advance. When it reaches 0, the next state is RUN.
- Stall watchdog:
  - stall_cnt increments on each RUN stall cycle and clears on any non-stall cycle. It saturates at 255.
  - stall_timeout sets when stall_cnt reaches MAX_STALL with hz_stall still 1. It stays set until reset; behaviour is otherwise unchanged.
- Reset asserted mid-operation forces BOOT immediately and clears all counters.

Optional Feature:
PC_SEQ_PERF_EN
- Defined:
  - perf_redirects increments on each redirect.
  - perf_stalls increments on each RUN stall cycle.
  - Both are 32-bit and saturate at 0xFFFFFFFF.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
1. Reset -> release -> advance: rst=0 for 2 cycles, then 1 with imem_ready=1. Expect fetch_valid=0 and pc_en=0 on the first edge, then pc_en=1 with all selects 0 for 5 cycles.
2. CBZ taken: ex_is_cb=1, ex_cond_met=1 for one cycle. Expect pc_en=1, pc_sel_branch=1, pc_sel_uncond=0, ifid_flush=1, idex_flush=1. With FLUSH_DEPTH=2, ex_is_b=1 on the next cycle is ignored (pc_sel_branch=0). Also check ex_cond_met=0 gives a plain advance.
3. Redirect beats stall: hz_stall=1, ex_is_br=1, imem_ready=0 in the same cycle. Expect pc_en=1, pc_sel_reg=1, pc_sel_branch=0.
4. Load-use stall for 3 cycles: expect pc_en=0, ifid_en=0, idex_flush=1 for 3 cycles, then an advance. With PC_SEQ_PERF_EN defined, perf_stalls=3.
5. Watchdog: hz_stall=1 for 16 cycles with MAX_STALL=16. Expect stall_timeout=1 from that point, still 1 after hz_stall drops, and 0 only after rst=0.
6. Reset while in SHADOW: branch taken, then rst=0 one cycle later. Expect immediate BOOT outputs (ifid_flush=1, pc_en=0) and perf counters at 0.
